// File: rtl/types_pkg.sv
// Shared pipeline types, including the data-memory request code and responder FSM states.
package types_pkg;

  typedef logic [15:0] uword16;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_RD   = 2'b01,
    MEM_WR   = 2'b10,
    MEM_WRB  = 2'b11
  } memc_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmem_state_e;

  localparam int CNT_W = 4;

  function automatic logic addr_in_range(input uword16 addr, input int unsigned depth);
    return {16'h0000, addr} < depth;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 16, byte-lane write enables, registered read.
// Contents are never reset.
module dmem_array
  import types_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  uword16        wdata_i,
  output uword16        rdata_o
);

  uword16 mem [DEPTH_WORDS];
  uword16 rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 2; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: latches a request, waits LATENCY cycles, then performs it.
// Optional feature macro: DMEM_BYTE_WR_EN (MEM_WRB writes only the low byte).
module dmem_responder
  import types_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_memc,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        mem_stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  memc_e            req_op;
  dmem_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  memc_e            op_q;
  logic [AW-1:0]    addr_q;
  uword16           wdata_q;
  logic             oor_q;
  logic             rd_valid_q;
  uword16           rd_data_q;
  logic             addr_err_q;

  logic             access_d;
  logic             ram_we_d;
  logic [1:0]       ram_be_d;
  uword16           ram_rdata;
  uword16           rd_data_d;

  assign req_op = memc_e'(req_memc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= MEM_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      // Fold the completed load into the holding register at the end of DONE.
      if (rd_valid_q) rd_data_q <= rd_data_d;
      case (state_q)
        IDLE: begin
          if (req_op != MEM_NONE) begin
            op_q    <= req_op;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            oor_q   <= !addr_in_range(req_addr, DEPTH_WORDS);
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= DONE;
            rd_valid_q <= (op_q == MEM_RD);
            if (oor_q) addr_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM is touched only on the WAIT->DONE edge, and never for an out-of-range address.
  assign access_d = (state_q == WAIT) && (cnt_q == '0) && !oor_q;
  assign ram_we_d = (op_q == MEM_WR) || (op_q == MEM_WRB);

`ifdef DMEM_BYTE_WR_EN
  assign ram_be_d = (op_q == MEM_WRB) ? 2'b01 : 2'b11;
`else
  assign ram_be_d = 2'b11;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .en_i    (access_d),
    .we_i    (ram_we_d),
    .be_i    (ram_be_d),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign rd_data_d = rd_valid_q ? (oor_q ? 16'h0000 : ram_rdata) : rd_data_q;

  assign mem_stall = rst && (((state_q == IDLE) && (req_op != MEM_NONE)) || (state_q == WAIT));
  assign rd_data   = rd_data_d;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2) against a word-array model.
// Honours DMEM_BYTE_WR_EN for the expected MEM_WRB result.
module tb_dmem_responder;
  import types_pkg::*;

  localparam int L     = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_memc;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        mem_stall;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        addr_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] model_mem [int];
  int          pool [$];
  logic [15:0] exp_rd  = 16'h0000;
  bit          exp_err = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_memc  (req_memc),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_stall (mem_stall),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .addr_err  (addr_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access: accept in the current IDLE cycle, L WAIT cycles, DONE, then return at IDLE.
  task automatic access(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit scramble, input bit hold, input string tag);
    logic [15:0] exp;
    int          a;
    a   = int'(addr);
    exp = 16'h0000;
    if (op == MEM_RD && a < DEPTH && model_mem.exists(a)) exp = model_mem[a];

    req_memc = op; req_addr = addr; req_wdata = wdata;
    #1;
    vectors++;
    if (mem_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept_stall: got %b want 1", tag, mem_stall);
    end
    for (int i = 1; i <= L; i++) begin
      next_cycle();
      if (scramble) begin
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
      end
      #1;
      vectors++;
      if (mem_stall !== 1'b1 || rd_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s wait%0d: stall=%b rd_valid=%b want stall=1 rd_valid=0", tag, i, mem_stall, rd_valid);
      end
    end

    next_cycle();
    if (!hold) req_memc = MEM_NONE;
    #1;
    if (a >= DEPTH) exp_err = 1'b1;
    else if (op == MEM_WR) begin
      model_mem[a] = wdata;
      pool.push_back(a);
    end else if (op == MEM_WRB) begin
`ifdef DMEM_BYTE_WR_EN
      model_mem[a] = {model_mem[a][15:8], wdata[7:0]};
`else
      model_mem[a] = wdata;
`endif
    end
    if (op == MEM_RD) exp_rd = exp;

    vectors++;
    if (mem_stall !== 1'b0 || rd_valid !== (op == MEM_RD) || rd_data !== exp_rd || addr_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s done: stall=%b rd_valid=%b rd_data=%h addr_err=%b want 0 %b %h %b",
               tag, mem_stall, rd_valid, rd_data, addr_err, (op == MEM_RD), exp_rd, exp_err);
    end
    $display("txn %-10s op=%0d addr=%h wdata=%h rd_data=%h addr_err=%b", tag, op, addr, wdata, rd_data, addr_err);
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; req_memc = MEM_NONE; req_addr = '0; req_wdata = '0;
    next_cycle();
    next_cycle();
    vectors++;
    if (mem_stall !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0000 || addr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: stall=%b rd_valid=%b rd_data=%h addr_err=%b want all 0", mem_stall, rd_valid, rd_data, addr_err);
    end
    rst = 1'b1;
    next_cycle();
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_stall: got %b want 0", mem_stall);
    end
  endtask

  task automatic test_write_read();
    access(MEM_WR, 16'h0010, 16'hBEEF, 1'b0, 1'b0, "wr_beef");
    access(MEM_RD, 16'h0010, 16'h0000, 1'b0, 1'b0, "rd_beef");
    vectors++;
    if (rd_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL rd_hold_idle: got %h want BEEF", rd_data);
    end
  endtask

  task automatic test_byte_write();
    access(MEM_WRB, 16'h0010, 16'h0012, 1'b0, 1'b0, "wrb");
    access(MEM_RD,  16'h0010, 16'h0000, 1'b0, 1'b0, "rd_wrb");
  endtask

  task automatic test_out_of_range();
    access(MEM_WR, 16'h0000, 16'h5A5A, 1'b0, 1'b0, "wr_0");
    access(MEM_WR, 16'h0100, 16'h1234, 1'b0, 1'b0, "wr_oor");
    access(MEM_RD, 16'h0000, 16'h0000, 1'b0, 1'b0, "rd_0");
    access(MEM_RD, 16'h0100, 16'h0000, 1'b0, 1'b0, "rd_oor");
    access(MEM_RD, 16'h0010, 16'h0000, 1'b0, 1'b0, "rd_sticky");
  endtask

  task automatic test_input_stability();
    access(MEM_WR, 16'h0030, 16'hA5A5, 1'b1, 1'b0, "wr_scram");
    access(MEM_RD, 16'h0030, 16'h0000, 1'b1, 1'b1, "rd_hold");
    access(MEM_RD, 16'h0030, 16'h0000, 1'b0, 1'b0, "rd_again");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [15:0] addr;
    for (int n = 0; n < 30; n++) begin
      op   = 2'($urandom_range(1, 3));
      addr = 16'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) addr = 16'($urandom_range(DEPTH, 65535));
      else if (op != MEM_WR) addr = 16'(pool[$urandom_range(0, pool.size() - 1)]);
      access(op, addr, 16'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_wait();
    access(MEM_WR, 16'h0020, 16'h1111, 1'b0, 1'b0, "wr_1111");
    req_memc = MEM_WR; req_addr = 16'h0020; req_wdata = 16'h2222;
    next_cycle();
    rst = 1'b0;
    #1;
    exp_rd  = 16'h0000;
    exp_err = 1'b0;
    vectors++;
    if (mem_stall !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 16'h0000 || addr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_wait: stall=%b rd_valid=%b rd_data=%h addr_err=%b want all 0", mem_stall, rd_valid, rd_data, addr_err);
    end
    req_memc = MEM_NONE;
    next_cycle();
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wait_release: got %b want 0", mem_stall);
    end
    next_cycle();
    access(MEM_RD, 16'h0020, 16'h0000, 1'b0, 1'b0, "rd_1111");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_input_stability();
    test_back_to_back();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the memory-stage side of the pipeline. It accepts the load/store request carried by stage three (`memc`, ALU address, R1 store data), inserts a configurable number of wait states, and holds the pipeline with a stall until the access completes. It then returns load data and reports out-of-range addresses.

## Interface

Parameters:
- `DEPTH_WORDS`, default 256: number of 16-bit words; must be a power of two, at most 65536.
- `LATENCY`, default 2: wait states per access; legal range 1..15.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_memc`  in  2: `memc_e` request code: `MEM_NONE`=00, `MEM_RD`=01, `MEM_WR`=10, `MEM_WRB`=11.
- `req_addr`  in  16: word address, from the stage-three ALU result low 16 bits.
- `req_wdata`  in  16: store data, from stage-three R1 data.
- `mem_stall`  out  1: pipeline hold. While high, stages one to three must not advance.
- `rd_data`  out  16: last completed load data.
- `rd_valid`  out  1: one-cycle pulse when `rd_data` updates.
- `addr_err`  out  1: sticky flag for an out-of-range access.

## Operation

- State machine with three states: `IDLE`, `WAIT`, `DONE`.
- **`IDLE`**
  - If `req_memc != MEM_NONE`: latch op, address and wdata; load `cnt = LATENCY-1`; go to `WAIT`.
  - `mem_stall` is combinationally high in this cycle.
- **`WAIT`**
  - `mem_stall = 1`.
  - If `cnt == 0`: perform the access on the edge and go to `DONE`. Otherwise decrement `cnt`.
  - Input changes during `WAIT` are ignored; only the latched values are used.
- **`DONE`**
  - `mem_stall = 0`.
  - Always returns to `IDLE` without sampling inputs. The request bus still shows the completing request during this cycle.
- **Access performed on the `WAIT`→`DONE` edge:**
  - `MEM_RD`: `rd_data <= mem[addr]`; `rd_valid = 1` during `DONE` only.
  - `MEM_WR`: `mem[addr] <= wdata`.
  - `MEM_WRB`: see Configuration.
- **Range check:** an address is out of range when `addr >= DEPTH_WORDS`.
  - No write is performed; there is no aliasing.
  - A read returns `16'h0000`.
  - `addr_err` is set on the `DONE` edge and cleared only by reset.
- Memory contents are not cleared by reset and are undefined at power-up.

## Timing

- Request visible in cycle T:
  - `mem_stall` is high in cycles T..T+LATENCY, which is LATENCY+1 cycles.
  - The state is `DONE` in cycle T+LATENCY+1, where `rd_valid` pulses for reads.
- Back-to-back requests: the earliest next acceptance is cycle T+LATENCY+2. Throughput is one access per LATENCY+2 cycles.
- A write followed by a read of the same address returns the new data.
- `rd_data` holds its value through writes and idle cycles.
- Reset asserted (`rst` = 0), at any time:
  - Immediately: state `IDLE`, `cnt = 0`, `mem_stall = 0`, `rd_valid = 0`, `rd_data = 16'h0000`, `addr_err = 0`.
  - A write not yet committed is dropped.
- Reset deasserted with a request present: the request is accepted in that cycle as in `IDLE`.

## Configuration

- Macro `DMEM_BYTE_WR_EN`:
  - Defined: `MEM_WRB` writes only `wdata[7:0]` into the low byte and preserves `mem[addr][15:8]`.
  - Undefined: `MEM_WRB` behaves exactly like `MEM_WR`, as a full-word write, and no byte-enable logic is built.

## Structure

- `types_pkg` gains the `memc_e` enum (`MEM_NONE`, `MEM_RD`, `MEM_WR`, `MEM_WRB`) and the `dmem_state_e` enum. Store data and read data use the existing `uword16`.
- Sub-module `dmem_array`: single-port synchronous RAM of `DEPTH_WORDS` x 16 with a 2-bit byte enable, one write or one read per edge, and no reset. The byte-enable input is tied to 2'b11 when `DMEM_BYTE_WR_EN` is undefined.
- The FSM, counter, latches and range check live in `dmem_responder`.

## Test plan

- **Reset:** drive `rst`=0 mid-stream → all outputs 0 in the same cycle and state `IDLE`. Release with `req_memc=MEM_NONE` → `mem_stall` stays 0.
- **Write then read** (LATENCY=2): write `16'hBEEF` to `0x0010` in cycle T → `mem_stall` high in T..T+2. Then read `0x0010` → `rd_valid` pulse 3 cycles after acceptance, `rd_data=16'hBEEF`.
- **Byte write:** `0x0010` holds `BEEF`; issue `MEM_WRB` with data `16'h0012`, then read → `16'hBE12` with the macro defined, `16'h0012` without it.
- **Out of range** (DEPTH_WORDS=256): write `16'h1234` to `0x0100`, then read `0x0000` → old `0x0000` contents unchanged. Read `0x0100` → `rd_data=0`, `addr_err=1`, and it stays 1 across later good accesses.
- **Reset during `WAIT`:** with `0x0020`=`16'h1111`, write `16'h2222` and assert reset in the first `WAIT` cycle → `mem_stall` drops immediately. A later read of `0x0020` returns `16'h1111`.
- **Input stability:** change `req_addr` and `req_wdata` during `WAIT` → the latched values are used. Hold the request through `DONE` → it is not re-executed, and the next acceptance occurs only in the following `IDLE` cycle.
